// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes, bridge FSM encodings and a constant clog2 helper
package axi4_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B, W_ERR} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_ERR} rd_state_t;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi4_lite_addr_decoder.sv
// axi4_lite_addr_decoder: maps a byte address to a slave port; lowest matching index wins
module axi4_lite_addr_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter int IDX_WIDTH  = 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_1000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {2{32'hFFFF_F000}}
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic [IDX_WIDTH-1:0]  o_idx
);
    // Scan downwards so the lowest matching slot is the last one written
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((i_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                o_hit    = 1'b1;
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_idx    = IDX_WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: turns single-shot read/write requests into AXI4-Lite transactions
// to NUM_SLAVES decoded peripherals, with independent read/write FSMs and a per-transaction timeout.
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_1000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {2{32'hFFFF_F000}},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             write_start,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [DATA_WIDTH/8-1:0]          write_strobe,
    output logic                             write_busy,
    input  logic                             read_start,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             read_busy,
    output logic                             write_err,
    output logic                             read_err,
    output logic [ADDR_WIDTH-1:0]            m_awaddr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic [NUM_SLAVES-1:0]            m_awvalid,
    output logic [NUM_SLAVES-1:0]            m_wvalid,
    output logic [NUM_SLAVES-1:0]            m_bready,
    output logic [NUM_SLAVES-1:0]            m_arvalid,
    output logic [NUM_SLAVES-1:0]            m_rready,
    input  logic [NUM_SLAVES-1:0]            m_awready,
    input  logic [NUM_SLAVES-1:0]            m_wready,
    input  logic [NUM_SLAVES-1:0]            m_bvalid,
    input  logic [NUM_SLAVES-1:0]            m_arready,
    input  logic [NUM_SLAVES-1:0]            m_rvalid,
    input  logic [2*NUM_SLAVES-1:0]          m_bresp,
    input  logic [DATA_WIDTH*NUM_SLAVES-1:0] m_rdata,
    input  logic [2*NUM_SLAVES-1:0]          m_rresp
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = NUM_SLAVES > 1 ? clog2(NUM_SLAVES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    wr_state_t              r_wstate;
    rd_state_t              r_rstate;
    logic [NUM_SLAVES-1:0]  r_wsel, r_rsel, r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [IW-1:0]          r_widx, r_ridx;
    logic [TW-1:0]          r_wcnt, r_rcnt;
    logic                   r_werr, r_rerr;
    logic [ADDR_WIDTH-1:0]  r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
    logic [SW-1:0]          r_wstrb;

    logic                   w_whit, w_rhit;
    logic [NUM_SLAVES-1:0]  w_wsel, w_rsel;
    logic [IW-1:0]          w_widx, w_ridx;

    axi4_lite_addr_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES), .IDX_WIDTH(IW),
        .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
    ) u_wdec (.i_addr(write_addr), .o_hit(w_whit), .o_sel(w_wsel), .o_idx(w_widx));

    axi4_lite_addr_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES), .IDX_WIDTH(IW),
        .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
    ) u_rdec (.i_addr(read_addr), .o_hit(w_rhit), .o_sel(w_rsel), .o_idx(w_ridx));

    // A channel counts as done once its valid has already dropped or handshakes this cycle
    wire w_aw_ok = ~|r_awvalid | |(r_awvalid & m_awready);
    wire w_w_ok  = ~|r_wvalid | |(r_wvalid & m_wready);
    wire w_b_hs  = |(r_bready & m_bvalid);
    wire w_ar_hs = |(r_arvalid & m_arready);
    wire w_r_hs  = |(r_rready & m_rvalid);
    wire w_wto   = (TIMEOUT_CYCLES != 0) && (r_wcnt == TMAX);
    wire w_rto   = (TIMEOUT_CYCLES != 0) && (r_rcnt == TMAX);
    wire [1:0] w_bresp = m_bresp[r_widx*2 +: 2];
    wire [1:0] w_rresp = m_rresp[r_ridx*2 +: 2];
    wire [DATA_WIDTH-1:0] w_rdata = m_rdata[r_ridx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_wsel    <= '0;
            r_widx    <= '0;
            r_awvalid <= '0;
            r_wvalid  <= '0;
            r_bready  <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_werr <= 1'b0;
            r_wcnt <= r_wcnt + TW'(1);
            case (r_wstate)
                W_IDLE: if (write_start) begin
                    r_wcnt   <= '0;
                    r_wstate <= w_whit ? W_AW_W : W_ERR;
                    r_werr   <= ~w_whit;
                    if (w_whit) begin
                        r_awaddr  <= write_addr;
                        r_wdata   <= write_data;
                        r_wstrb   <= write_strobe;
                        r_wsel    <= w_wsel;
                        r_widx    <= w_widx;
                        r_awvalid <= w_wsel;
                        r_wvalid  <= w_wsel;
                    end
                end
                W_AW_W: if (w_wto) begin
                    r_wstate  <= W_IDLE;
                    r_awvalid <= '0;
                    r_wvalid  <= '0;
                    r_werr    <= 1'b1;
                end else if (w_aw_ok && w_w_ok) begin
                    r_wstate  <= W_B;
                    r_awvalid <= '0;
                    r_wvalid  <= '0;
                    r_bready  <= r_wsel;
                end else begin
                    if (|(r_awvalid & m_awready)) r_awvalid <= '0;
                    if (|(r_wvalid & m_wready)) r_wvalid <= '0;
                end
                W_B: if (w_b_hs || w_wto) begin
                    r_wstate <= W_IDLE;
                    r_bready <= '0;
                    r_werr   <= w_b_hs ? (w_bresp != RESP_OKAY) : 1'b1;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_rsel    <= '0;
            r_ridx    <= '0;
            r_arvalid <= '0;
            r_rready  <= '0;
            r_rcnt    <= '0;
            r_rerr    <= 1'b0;
            r_araddr  <= '0;
            r_rdata   <= '0;
        end else begin
            r_rerr <= 1'b0;
            r_rcnt <= r_rcnt + TW'(1);
            case (r_rstate)
                R_IDLE: if (read_start) begin
                    r_rcnt   <= '0;
                    r_rstate <= w_rhit ? R_AR : R_ERR;
                    r_rerr   <= ~w_rhit;
                    if (w_rhit) begin
                        r_araddr  <= read_addr;
                        r_rsel    <= w_rsel;
                        r_ridx    <= w_ridx;
                        r_arvalid <= w_rsel;
                    end else begin
                        r_rdata <= '0;
                    end
                end
                R_AR: if (w_rto) begin
                    r_rstate  <= R_IDLE;
                    r_arvalid <= '0;
                    r_rerr    <= 1'b1;
                    r_rdata   <= '0;
                end else if (w_ar_hs) begin
                    r_rstate  <= R_R;
                    r_arvalid <= '0;
                    r_rready  <= r_rsel;
                end
                R_R: if (w_r_hs) begin
                    r_rstate <= R_IDLE;
                    r_rready <= '0;
                    r_rdata  <= w_rdata;
                    r_rerr   <= w_rresp != RESP_OKAY;
                end else if (w_rto) begin
                    r_rstate <= R_IDLE;
                    r_rready <= '0;
                    r_rerr   <= 1'b1;
                    r_rdata  <= '0;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Busy includes the start cycle itself so the core stalls immediately; gated low during reset
    assign write_busy = rst & ((r_wstate != W_IDLE) | write_start);
    assign read_busy  = rst & ((r_rstate != R_IDLE) | read_start);
    assign write_err  = r_werr;
    assign read_err   = r_rerr;
    assign read_data  = r_rdata;
    assign m_awaddr   = r_awaddr;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_araddr   = r_araddr;
    assign m_awvalid  = r_awvalid;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// tb_axi4_lite_master_bridge: directed checks of the AXI4-Lite master bridge against hand-computed values
module tb_axi4_lite_master_bridge;
    logic        clk, rst;
    logic        write_start, read_start;
    logic [31:0] write_addr, write_data, read_addr;
    logic [3:0]  write_strobe;
    logic        write_busy, read_busy, write_err, read_err;
    logic [31:0] read_data, m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [3:0]  m_bresp, m_rresp;
    logic [63:0] m_rdata;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc;

    axi4_lite_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_busy(write_busy),
        .read_start(read_start), .read_addr(read_addr), .read_data(read_data), .read_busy(read_busy),
        .write_err(write_err), .read_err(read_err),
        .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_araddr(m_araddr),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_rready(m_rready),
        .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
        .m_arready(m_arready), .m_rvalid(m_rvalid),
        .m_bresp(m_bresp), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        write_start = 0; read_start = 0;
        write_addr = 0; write_data = 0; write_strobe = 0; read_addr = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        step;
        check("rst awvalid", m_awvalid, 0);
        check("rst arvalid", m_arvalid, 0);
        check("rst readies", {m_bready, m_rready, m_wvalid}, 0);
        check("rst busy", {write_busy, read_busy}, 0);
        check("rst err", {write_err, read_err}, 0);
        check("rst read_data", read_data, 0);
        check("rst awaddr", m_awaddr, 0);
        rst = 1'b1;
        step;

        // Write to slave1: wready one cycle in, awready two cycles in
        write_start = 1; write_addr = 32'h8000_1004; write_data = 32'hA5A5_0001; write_strobe = 4'hF;
        #1 check("t1 busy start", write_busy, 1);
        step; write_start = 0;
        check("t1 awvalid", m_awvalid, 2'b10);
        check("t1 wvalid", m_wvalid, 2'b10);
        check("t1 awaddr", m_awaddr, 32'h8000_1004);
        check("t1 wdata", m_wdata, 32'hA5A5_0001);
        check("t1 wstrb", m_wstrb, 4'hF);
        m_wready = 2'b10;
        step; m_wready = 0;
        check("t1 wvalid drop", m_wvalid, 0);
        check("t1 awvalid hold", m_awvalid, 2'b10);
        m_awready = 2'b10;
        step; m_awready = 0;
        check("t1 awvalid drop", m_awvalid, 0);
        check("t1 bready", m_bready, 2'b10);
        check("t1 busy in B", write_busy, 1);
        m_bvalid = 2'b10; m_bresp = 4'b0000;
        step; m_bvalid = 0;
        check("t1 busy end", write_busy, 0);
        check("t1 err", write_err, 0);
        check("t1 bready end", m_bready, 0);

        // Read from slave0
        read_start = 1; read_addr = 32'h8000_0010;
        #1 check("t2 busy start", read_busy, 1);
        step; read_start = 0;
        check("t2 arvalid", m_arvalid, 2'b01);
        check("t2 araddr", m_araddr, 32'h8000_0010);
        m_arready = 2'b01;
        step; m_arready = 0;
        check("t2 arvalid drop", m_arvalid, 0);
        check("t2 rready", m_rready, 2'b01);
        m_rvalid = 2'b01; m_rdata = {32'hDEAD_BEEF, 32'h1234_5678}; m_rresp = 4'b0000;
        step; m_rvalid = 0;
        check("t2 busy end", read_busy, 0);
        check("t2 read_data", read_data, 32'h1234_5678);
        check("t2 err", read_err, 0);
        check("t2 rready end", m_rready, 0);

        // Unmapped read
        read_start = 1; read_addr = 32'h0000_0000;
        step; read_start = 0;
        check("t3 arvalid", m_arvalid, 0);
        check("t3 err pulse", read_err, 1);
        check("t3 busy", read_busy, 1);
        check("t3 read_data", read_data, 0);
        step;
        check("t3 err end", read_err, 0);
        check("t3 busy end", read_busy, 0);

        // Write to slave0 with awready/wready held low: abort after 16 cycles
        write_start = 1; write_addr = 32'h8000_0000; write_data = 32'h0000_0077; write_strobe = 4'h1;
        step; write_start = 0;
        check("t4 awvalid", m_awvalid, 2'b01);
        cyc = 0;
        while (write_busy && cyc < 100) begin
            cyc++;
            step;
        end
        check("t4 timeout cycles", cyc, 16);
        check("t4 err pulse", write_err, 1);
        check("t4 valids dropped", {m_awvalid, m_wvalid, m_bready}, 0);
        m_bvalid = 2'b01; m_bresp = 4'b0000;
        step; m_bvalid = 0;
        check("t4 late b err", write_err, 0);
        check("t4 late b bready", m_bready, 0);
        check("t4 late b busy", write_busy, 0);

        // Concurrent write to slave0 and read from slave1; a second read start is ignored
        write_start = 1; write_addr = 32'h8000_0008; write_data = 32'h0BAD_F00D; write_strobe = 4'h3;
        read_start = 1; read_addr = 32'h8000_1020;
        step; write_start = 0;
        read_start = 1; read_addr = 32'h8000_0000;
        check("t5 awvalid", m_awvalid, 2'b01);
        check("t5 wdata", m_wdata, 32'h0BAD_F00D);
        check("t5 wstrb", m_wstrb, 4'h3);
        check("t5 arvalid", m_arvalid, 2'b10);
        m_awready = 2'b01; m_wready = 2'b01; m_arready = 2'b10;
        step; read_start = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        check("t5 bready", m_bready, 2'b01);
        check("t5 rready", m_rready, 2'b10);
        check("t5 araddr kept", m_araddr, 32'h8000_1020);
        m_rvalid = 2'b10; m_rdata = {32'hCAFE_0002, 32'h1111_2222}; m_rresp = 4'b0000;
        step; m_rvalid = 0;
        check("t5 read done", read_busy, 0);
        check("t5 read_data", read_data, 32'hCAFE_0002);
        check("t5 write still busy", write_busy, 1);
        m_bvalid = 2'b01; m_bresp = 4'b0010;
        step; m_bvalid = 0; m_bresp = 0;
        check("t5 write done", write_busy, 0);
        check("t5 slverr", write_err, 1);
        check("t5 no second read", {read_busy, m_arvalid}, 0);
        step;
        check("t5 err end", write_err, 0);

        // Reset asserted while waiting for rvalid
        read_start = 1; read_addr = 32'h8000_1000;
        step; read_start = 0;
        m_arready = 2'b10;
        step; m_arready = 0;
        check("t6 rready", m_rready, 2'b10);
        #2 rst = 1'b0;
        #1 check("t6 rst rready", m_rready, 0);
        check("t6 rst busy", read_busy, 0);
        check("t6 rst arvalid", m_arvalid, 0);
        check("t6 rst read_data", read_data, 0);
        step; rst = 1'b1;
        check("t6 no err", read_err, 0);
        step;
        read_start = 1; read_addr = 32'h8000_1000;
        step; read_start = 0;
        check("t6 arvalid again", m_arvalid, 2'b10);
        m_arready = 2'b10;
        step; m_arready = 0;
        m_rvalid = 2'b10; m_rdata = {32'h5555_AAAA, 32'h0000_0000};
        step; m_rvalid = 0;
        check("t6 read_data", read_data, 32'h5555_AAAA);
        check("t6 busy end", read_busy, 0);
        check("t6 err", read_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
Parametrised successor of the core-to-peripheral AXI4-Lite path. Converts the memory stage's single-shot read/write start/busy requests into AXI4-Lite transactions to NUM_SLAVES peripherals. Adds address decoding, independent read/write FSMs, a per-transaction timeout, and error reporting. Sits between mem_stage and the peripheral slaves at SoC top level.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
NUM_SLAVES, 2, number of AXI4-Lite slave ports (1..8)
SLAVE_BASE, {32'h8000_1000, 32'h8000_0000}, packed NUM_SLAVES*ADDR_WIDTH bases; slot 0 is the LSBs
SLAVE_MASK, {2{32'hFFFF_F000}}, packed match masks: hit when (addr & mask) == base
TIMEOUT_CYCLES, 256, cycles in a non-idle state before abort; 0 disables

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
write_start  in  1  write request pulse
write_addr  in  ADDR_WIDTH  write byte address
write_data  in  DATA_WIDTH  write data
write_strobe  in  DATA_WIDTH/8  byte strobes
write_busy  out  1  write in progress
read_start  in  1  read request pulse
read_addr  in  ADDR_WIDTH  read byte address
read_data  out  DATA_WIDTH  registered read result
read_busy  out  1  read in progress
write_err  out  1  one-cycle pulse: write ended with SLVERR/DECERR/timeout
read_err  out  1  one-cycle pulse: read ended with error
m_awaddr, m_wdata, m_wstrb, m_araddr  out  ADDR/DATA/STRB widths  broadcast to all slaves, registered
m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  NUM_SLAVES  per-slave one-hot
m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  NUM_SLAVES  per-slave
m_bresp  in  2*NUM_SLAVES  per-slave write response
m_rdata  in  DATA_WIDTH*NUM_SLAVES  per-slave read data
m_rresp  in  2*NUM_SLAVES  per-slave read response

Behaviour:
- Reset (rst low, async): both FSMs IDLE; all valid/ready outputs 0; read_data 0; busy and err outputs 0; address/data registers 0.
- Decode: lowest-index matching slave wins; no match gives a decode error. Selection is latched at start.
- Write FSM: W_IDLE -> W_AW_W on write_start with a hit; latch addr/data/strobe/slave index and assert awvalid and wvalid to that slave only. Drop each valid independently on its handshake. When both handshakes are done -> W_B with bready=1. On bvalid -> W_IDLE; write_err pulses if bresp != OKAY.
- Write with no hit: W_IDLE -> W_ERR for one cycle with no AXI activity, write_err pulses, then W_IDLE.
- Read FSM: R_IDLE -> R_AR on read_start (hit); arvalid until arready -> R_R with rready=1. On rvalid: latch rdata into read_data -> R_IDLE; read_err pulses if rresp != OKAY. No hit: R_ERR for one cycle, read_data=0, read_err pulses.
- busy = (state != IDLE) | start, combinational, so the pipeline stalls in the start cycle. busy falls the cycle after the final handshake. read_data is valid from the first cycle read_busy is low and holds until the next read completes.
- start while busy is ignored. The read and write FSMs run concurrently; simultaneous starts are both accepted.
- Timeout: a per-FSM counter clears on entering a non-idle state and increments each cycle. At TIMEOUT_CYCLES-1 the FSM drops all valid/ready, returns to IDLE and pulses err. An aborted read gives read_data = 0. The counter width is clog2(TIMEOUT_CYCLES+1).
- Late responses from a timed-out slave are ignored; ready is never asserted outside the owning state.
- Reset mid-transaction: all outputs return to reset values immediately; no completion pulse is issued.

Decomposition:
- Package axi4_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, FSM state encodings, clog2 function.
- Sub-module axi4_lite_addr_decoder (combinational, parametrised): addr -> hit, one-hot select, index. Shared by both FSMs.

Test Plan:
- Write 0x8000_1004 data 0xA5A5_0001 strobe 4'hF; slave1 awready after 2 cycles, wready after 1, bresp OKAY -> only slave1 valids; write_busy falls the cycle after bvalid; write_err stays 0.
- Read 0x8000_0010; slave0 returns rdata 0x1234_5678, rresp OKAY -> read_data = 0x1234_5678 when read_busy falls; slave1 ready/valid never asserted.
- Read 0x0000_0000 (unmapped) -> no m_arvalid; read_err pulses 1 cycle; read_data 0; busy for 1 cycle.
- Write to slave0 with awready held 0 and TIMEOUT_CYCLES=16 -> abort after 16 cycles; write_err pulses; a later bvalid is ignored.
- Simultaneous write_start to slave0 and read_start to slave1 -> both complete independently with correct data; a second read_start while busy is ignored.
- Deassert rst during R_R -> m_rready, read_busy and arvalid go 0 asynchronously; no read_err; the next read after release works normally.
